// File: rtl/ad9854_sweep_ctrl_if.sv
// Request/status handshake from the panel logic plus the AD9854 parallel-bus pins.
// The sweep controller is the slave of the request side and drives every DDS pin.
interface ad9854_sweep_ctrl_if;
  localparam int unsigned FTW_W  = 48;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;

  logic              start;
  logic              mode;
  logic [FTW_W-1:0]  freq_start;
  logic [FTW_W-1:0]  freq_stop;
  logic [FTW_W-1:0]  freq_step;
  logic              busy;
  logic              done;
  logic [FTW_W-1:0]  cur_freq;
  logic              MRST;
  logic              WR;
  logic              RD;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] D;
  logic              UDCLK;
  logic              FBH;
  logic              OSK;

  modport master (
    output start, mode, freq_start, freq_stop, freq_step,
    input  busy, done, cur_freq, MRST, WR, RD, A, D, UDCLK, FBH, OSK
  );

  modport slave (
    input  start, mode, freq_start, freq_stop, freq_step,
    output busy, done, cur_freq, MRST, WR, RD, A, D, UDCLK, FBH, OSK
  );
endinterface

// File: rtl/ad9854_sweep_ctrl.sv
// AD9854 bus sequencer: chip reset + control-register init on first run, then
// FTW1 load and I/O update per point, stepping from start to stop in sweep mode.
module ad9854_sweep_ctrl #(
  parameter int unsigned WR_LOW    = 2,
  parameter int unsigned WR_HIGH   = 2,
  parameter int unsigned MRST_CYC  = 10,
  parameter int unsigned UDCLK_CYC = 4,
  parameter int unsigned DWELL     = 1000,
  parameter logic [31:0] CTRL_WORD = 32'h1044_0020
) (
  input  logic              clk,
  input  logic              rst_in,
  ad9854_sweep_ctrl_if.slave sweep
);
  localparam int unsigned FTW_W    = 48;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned BYTE_CYC = WR_LOW + WR_HIGH;
  localparam int unsigned CNT_W    = $clog2(MRST_CYC + BYTE_CYC + UDCLK_CYC + DWELL + 1);
  localparam int unsigned BYTE_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHIPRST,
    S_INITCR,
    S_LOAD,
    S_UPDATE,
    S_DWELL
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic                init_done_q, init_done_d;
  logic                mode_q, mode_d;
  logic [FTW_W-1:0]    stop_q, stop_d;
  logic [FTW_W-1:0]    step_q, step_d;
  logic [FTW_W-1:0]    ptr_q, ptr_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [FTW_W-1:0]    cur_freq_q, cur_freq_d;
  logic                mrst_q, mrst_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   d_q, d_d;
  logic                udclk_q, udclk_d;

  logic [FTW_W:0]      sum;
  logic                byte_end;
  logic                write_state;

  // Next-state and sequencing; pin values are then derived from the next state
  // so that every pin comes straight out of a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_d      = byte_q;
    init_done_d = init_done_q;
    mode_d      = mode_q;
    stop_d      = stop_q;
    step_d      = step_q;
    ptr_d       = ptr_q;
    a_d         = a_q;
    d_d         = d_q;
    cur_freq_d  = cur_freq_q;
    sum         = {1'b0, ptr_q} + {1'b0, step_q};
    byte_end    = (cnt_q == CNT_W'(BYTE_CYC - 1));
    write_state = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (sweep.start) begin
          mode_d  = sweep.mode;
          ptr_d   = sweep.freq_start;
          stop_d  = sweep.freq_stop;
          step_d  = sweep.freq_step;
          cnt_d   = '0;
          byte_d  = '0;
          state_d = init_done_q ? S_LOAD : S_CHIPRST;
        end
      end
      S_CHIPRST: begin
        if (cnt_q == CNT_W'(MRST_CYC - 1)) begin
          cnt_d   = '0;
          byte_d  = '0;
          state_d = S_INITCR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_INITCR: begin
        if (byte_end) begin
          cnt_d = '0;
          if (byte_q == BYTE_W'(3)) begin
            byte_d      = '0;
            init_done_d = 1'b1;
            state_d     = S_LOAD;
          end else begin
            byte_d = byte_q + BYTE_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOAD: begin
        if (byte_end) begin
          cnt_d = '0;
          if (byte_q == BYTE_W'(5)) begin
            byte_d  = '0;
            state_d = S_UPDATE;
          end else begin
            byte_d = byte_q + BYTE_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_UPDATE: begin
        if (cnt_q == CNT_W'(UDCLK_CYC - 1)) begin
          cnt_d      = '0;
          cur_freq_d = ptr_q;
          if (!mode_q || (ptr_q >= stop_q) || (step_q == '0)) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DWELL;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DWELL: begin
        if (cnt_q == CNT_W'(DWELL - 1)) begin
          cnt_d   = '0;
          byte_d  = '0;
          // Clamp to the stop word on overshoot or 48-bit wrap.
          ptr_d   = (sum[FTW_W] || (sum[FTW_W-1:0] > stop_q)) ? stop_q : sum[FTW_W-1:0];
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    write_state = (state_d == S_INITCR) || (state_d == S_LOAD);

    // A/D change only on the first cycle of a byte and hold otherwise.
    if (write_state && (cnt_d == '0)) begin
      if (state_d == S_INITCR) begin
        a_d = 6'h1D + {4'b0000, byte_d[1:0]};
        d_d = 8'(CTRL_WORD >> (5'd24 - {byte_d[1:0], 3'b000}));
      end else begin
        a_d = 6'h04 + {3'b000, byte_d};
        d_d = 8'(ptr_d >> (6'd40 - {byte_d, 3'b000}));
      end
    end

    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q != S_IDLE) && (state_d == S_IDLE);
    mrst_d  = (state_d == S_CHIPRST);
    udclk_d = (state_d == S_UPDATE);
    wr_d    = !(write_state && (cnt_d < CNT_W'(WR_LOW)));
  end

  // State, datapath and pin registers.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      byte_q      <= '0;
      init_done_q <= 1'b0;
      mode_q      <= 1'b0;
      stop_q      <= '0;
      step_q      <= '0;
      ptr_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cur_freq_q  <= '0;
      mrst_q      <= 1'b0;
      wr_q        <= 1'b1;
      a_q         <= '0;
      d_q         <= '0;
      udclk_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      init_done_q <= init_done_d;
      mode_q      <= mode_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cur_freq_q  <= cur_freq_d;
      mrst_q      <= mrst_d;
      wr_q        <= wr_d;
      a_q         <= a_d;
      d_q         <= d_d;
      udclk_q     <= udclk_d;
    end
  end

  assign sweep.busy     = busy_q;
  assign sweep.done     = done_q;
  assign sweep.cur_freq = cur_freq_q;
  assign sweep.MRST     = mrst_q;
  assign sweep.WR       = wr_q;
  assign sweep.A        = a_q;
  assign sweep.D        = d_q;
  assign sweep.UDCLK    = udclk_q;
  assign sweep.RD       = 1'b1;
  assign sweep.FBH      = 1'b0;
  assign sweep.OSK      = 1'b1;
endmodule

// File: tb/tb_ad9854_sweep_ctrl.sv
// Scoreboard bench for ad9854_sweep_ctrl: stimulus queues expected byte writes,
// UDCLK-latched FTWs and busy lengths; a negedge monitor pops and compares them.
module tb_ad9854_sweep_ctrl;
  localparam int unsigned DWELL_CYC = 1000;

  logic clk = 1'b0;
  logic rst_in;
  always #5 clk = ~clk;

  ad9854_sweep_ctrl_if sif ();

  ad9854_sweep_ctrl #(.DWELL(DWELL_CYC)) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .sweep  (sif)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [13:0] exp_wr_q[$];
  logic [47:0] exp_freq_q[$];
  int          exp_busy_q[$];

  bit   mon_en      = 1'b0;
  logic prev_wr     = 1'b1;
  logic prev_ud     = 1'b0;
  logic prev_mrst   = 1'b0;
  int   ud_cnt      = 0;
  int   mrst_cnt    = 0;
  int   busy_cnt    = 0;
  int   gap         = 0;
  bit   gap_armed   = 1'b0;
  int   mrst_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  task automatic push_wr(input logic [5:0] a, input logic [7:0] d);
    exp_wr_q.push_back({a, d});
  endtask

  task automatic push_cr();
    push_wr(6'h1D, 8'h10);
    push_wr(6'h1E, 8'h44);
    push_wr(6'h1F, 8'h00);
    push_wr(6'h20, 8'h20);
  endtask

  // One sweep point: FTW1 bytes MSB first at 0x04..0x09, then the latched word.
  task automatic push_point(input logic [47:0] w);
    for (int i = 0; i < 6; i++) push_wr(6'(4 + i), w[47 - 8*i -: 8]);
    exp_freq_q.push_back(w);
  endtask

  task automatic issue(input logic m, input logic [47:0] fs, input logic [47:0] fe,
                       input logic [47:0] fst);
    @(negedge clk);
    sif.mode       = m;
    sif.freq_start = fs;
    sif.freq_stop  = fe;
    sif.freq_step  = fst;
    sif.start      = 1'b1;
    @(negedge clk);
    sif.start      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!sif.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!sif.done) begin
      n_checks++;
      $display("FAIL %s: no done within %0d cycles, expected done", name, budget);
    end
  endtask

  // Monitor: byte writes on WR fall, FTW latch on UDCLK fall, run length on done.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_wr && !sif.WR) begin
        if (gap_armed) begin
          check("dwell_gap", 64'(gap), 64'(DWELL_CYC));
          gap_armed = 1'b0;
        end
        if (exp_wr_q.size() == 0) fail_event("unexpected_write");
        else check("byte_write", 64'({sif.A, sif.D}), 64'(exp_wr_q.pop_front()));
      end else if (gap_armed) begin
        gap++;
      end

      if (sif.UDCLK) begin
        ud_cnt++;
      end else if (prev_ud) begin
        check("udclk_width", 64'(ud_cnt), 64'd4);
        if (exp_freq_q.size() == 0) fail_event("unexpected_update");
        else check("cur_freq", 64'(sif.cur_freq), 64'(exp_freq_q.pop_front()));
        ud_cnt = 0;
        if (sif.busy) begin
          gap_armed = 1'b1;
          gap       = 1;
        end
      end

      if (sif.MRST) begin
        mrst_cnt++;
      end else if (prev_mrst) begin
        check("mrst_width", 64'(mrst_cnt), 64'd10);
        mrst_pulses++;
        mrst_cnt = 0;
      end

      if (sif.done) begin
        if (exp_busy_q.size() == 0) fail_event("unexpected_done");
        else check("busy_cycles", 64'(busy_cnt), 64'(exp_busy_q.pop_front()));
      end
      if (sif.busy) busy_cnt++;
      else busy_cnt = 0;

      prev_wr   = sif.WR;
      prev_ud   = sif.UDCLK;
      prev_mrst = sif.MRST;
    end
  end

  initial begin
    int n;
    rst_in         = 1'b1;
    sif.start      = 1'b0;
    sif.mode       = 1'b0;
    sif.freq_start = '0;
    sif.freq_stop  = '0;
    sif.freq_step  = '0;
    repeat (3) @(negedge clk);

    // busy,done,MRST,WR,RD,UDCLK,FBH,OSK
    check("reset_ctrl_pins", 64'({sif.busy, sif.done, sif.MRST, sif.WR, sif.RD,
                                  sif.UDCLK, sif.FBH, sif.OSK}), 64'(8'b0001_1001));
    check("reset_addr", 64'(sif.A), 64'd0);
    check("reset_data", 64'(sif.D), 64'd0);
    check("reset_cur_freq", 64'(sif.cur_freq), 64'd0);

    rst_in  = 1'b0;
    prev_wr = 1'b1;
    mon_en  = 1'b1;

    // First run: chip reset, CR init, one FTW.
    push_cr();
    push_wr(6'h04, 8'h01); push_wr(6'h05, 8'h47); push_wr(6'h06, 8'hAE);
    push_wr(6'h07, 8'h14); push_wr(6'h08, 8'h7A); push_wr(6'h09, 8'hE1);
    exp_freq_q.push_back(48'h0147_AE14_7AE1);
    exp_busy_q.push_back(54);
    issue(1'b0, 48'h0147_AE14_7AE1, 48'h0, 48'h0);
    wait_done("single_first", 200);

    // Second run: no re-init.
    push_wr(6'h04, 8'h00); push_wr(6'h05, 8'h00); push_wr(6'h06, 8'h00);
    push_wr(6'h07, 8'h00); push_wr(6'h08, 8'h00); push_wr(6'h09, 8'h05);
    exp_freq_q.push_back(48'd5);
    exp_busy_q.push_back(28);
    issue(1'b0, 48'd5, 48'h0, 48'h0);
    wait_done("single_second", 200);

    // Sweep landing exactly on stop.
    push_point(48'd100); push_point(48'd110); push_point(48'd120); push_point(48'd130);
    exp_busy_q.push_back(3112);
    issue(1'b1, 48'd100, 48'd130, 48'd10);
    wait_done("sweep_exact", 5000);

    // Sweep clamped to stop.
    push_point(48'd100); push_point(48'd110); push_point(48'd120); push_point(48'd125);
    exp_busy_q.push_back(3112);
    issue(1'b1, 48'd100, 48'd125, 48'd10);
    wait_done("sweep_clamp", 5000);

    // 48-bit wrap clamps to stop.
    push_point(48'hFFFF_FFFF_FFF0); push_point(48'hFFFF_FFFF_FFFF);
    exp_busy_q.push_back(1056);
    issue(1'b1, 48'hFFFF_FFFF_FFF0, 48'hFFFF_FFFF_FFFF, 48'h20);
    wait_done("sweep_wrap", 3000);

    // Zero step: single point.
    push_point(48'd500);
    exp_busy_q.push_back(28);
    issue(1'b1, 48'd500, 48'd900, 48'd0);
    wait_done("sweep_step0", 200);

    // Start above stop: single point.
    push_point(48'd200);
    exp_busy_q.push_back(28);
    issue(1'b1, 48'd200, 48'd100, 48'd10);
    wait_done("sweep_reversed", 200);

    // A start while busy must not disturb the sweep.
    push_point(48'd100); push_point(48'd110); push_point(48'd120);
    exp_busy_q.push_back(2084);
    issue(1'b1, 48'd100, 48'd120, 48'd10);
    repeat (1200) @(negedge clk);
    sif.mode       = 1'b0;
    sif.freq_start = 48'd999;
    sif.start      = 1'b1;
    @(negedge clk);
    sif.start      = 1'b0;
    wait_done("sweep_ignore_start", 5000);

    // Reset in the middle of the third FTW byte.
    push_wr(6'h04, 8'h00); push_wr(6'h05, 8'h00); push_wr(6'h06, 8'h00);
    issue(1'b1, 48'd100, 48'd130, 48'd10);
    n = 0;
    while (!(sif.WR == 1'b0 && sif.A == 6'h06) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      $display("FAIL reach_third_byte: got A=0x%0h, expected A=0x06 with WR low", sif.A);
    end
    rst_in = 1'b1;
    @(negedge clk);
    check("midrst_wr", 64'(sif.WR), 64'd1);
    check("midrst_addr", 64'(sif.A), 64'd0);
    check("midrst_data", 64'(sif.D), 64'd0);
    check("midrst_busy", 64'(sif.busy), 64'd0);
    check("midrst_cur_freq", 64'(sif.cur_freq), 64'd0);
    rst_in = 1'b0;

    // After reset the chip init runs again.
    push_cr();
    push_point(48'h0000_0000_1234);
    exp_busy_q.push_back(54);
    issue(1'b0, 48'h0000_0000_1234, 48'h0, 48'h0);
    wait_done("single_after_reset", 200);

    repeat (5) @(negedge clk);
    check("pending_writes", 64'(exp_wr_q.size()), 64'd0);
    check("pending_freqs", 64'(exp_freq_q.size()), 64'd0);
    check("pending_runs", 64'(exp_busy_q.size()), 64'd0);
    check("mrst_pulses", 64'(mrst_pulses), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ad9854_sweep_ctrl.md
Name: ad9854_sweep_ctrl

Overview:
Sequencer that owns the AD9854 DDS parallel bus and drives A/D/WR/UDCLK/MRST directly. On first start after reset it pulses MRST and writes the 4-byte control register. It then loads the 48-bit frequency tuning word FTW1 and issues an I/O update. In sweep mode it steps FTW1 from a start word to a stop word at a fixed dwell. It sits between the key/panel logic (start, mode, frequency words) and the AD9854 pins inside top_T.

Parameters:
WR_LOW, 2, cycles WR held low per byte write (min 1)
WR_HIGH, 2, cycles WR held high after each byte before next action (min 1)
MRST_CYC, 10, cycles MRST held high during chip reset
UDCLK_CYC, 4, cycles UDCLK held high per update
DWELL, 1000, cycles between end of UDCLK pulse and next point's first write (sweep only, min 1)
CTRL_WORD, 32'h10_44_00_20, bytes written to 0x1D,0x1E,0x1F,0x20 (MSB first); external update mode

Ports:
clk  in  1  system clock
rst_in  in  1  synchronous reset, active-high
start  in  1  one-cycle request; accepted only when busy=0
mode  in  1  0 = single point, 1 = sweep; sampled on accept
freq_start  in  48  first FTW; sampled on accept
freq_stop  in  48  final FTW (sweep); sampled on accept
freq_step  in  48  increment (sweep); sampled on accept
busy  out  1  high from accept cycle+1 until return to IDLE
done  out  1  one-cycle pulse on entering IDLE after a run
cur_freq  out  48  FTW most recently latched by UDCLK
MRST  out  1  AD9854 master reset
WR  out  1  AD9854 write strobe, active-low
RD  out  1  AD9854 read strobe, tied 1
A  out  6  AD9854 address
D  out  8  AD9854 data
UDCLK  out  1  AD9854 I/O update
FBH  out  1  tied 0
OSK  out  1  tied 1

Behaviour:
- Reset values: busy=0, done=0, cur_freq=0, MRST=0, WR=1, RD=1, A=0, D=0, UDCLK=0, FBH=0, OSK=1. Internal init_done=0 and state=IDLE.
- Reset taken mid-operation: all outputs return to reset values on the next edge. Any partial write is abandoned and init_done is cleared.
- States: IDLE, CHIPRST, INITCR, LOAD, UPDATE, DWELL.
- IDLE:
  - On start with busy=0, latch the inputs and set ptr=freq_start.
  - If init_done=0, go to CHIPRST; otherwise go to LOAD.
  - start while busy=1 is ignored.
- CHIPRST: MRST=1 for MRST_CYC cycles, then MRST=0 and go to INITCR.
- Byte write primitive:
  - A/D are driven on the first cycle of the primitive.
  - WR=0 for WR_LOW cycles, then WR=1 for WR_HIGH cycles.
  - A/D are held stable for the full WR_LOW+WR_HIGH window.
  - WR_LOW+WR_HIGH cycles per byte. Consecutive bytes are back-to-back.
- INITCR: 4 byte writes of CTRL_WORD bytes [31:24]..[7:0] to A=0x1D..0x20. Then set init_done=1 and go to LOAD.
- LOAD: 6 byte writes of ptr[47:40]..ptr[7:0] to A=0x04..0x09, then go to UPDATE.
- UPDATE:
  - UDCLK=1 for UDCLK_CYC cycles.
  - cur_freq<=ptr on the cycle UDCLK falls.
  - Then evaluate the next step.
- Next-step rule:
  - Finish (IDLE, done pulse) when any of these holds: mode=0, ptr>=stop, or step=0.
  - Otherwise go to DWELL.
- DWELL: count DWELL cycles, then compute sum = ptr+step as a 49-bit value.
  - If sum[48]=1 or sum>stop, set ptr=stop.
  - Else set ptr=sum[47:0].
  - Go to LOAD.
- freq_start>freq_stop in sweep mode: the single point freq_start is emitted, then done.
- Timing with default parameters:
  - First run, single mode: 10 (MRST) + 16 (CR) + 24 (FTW) + 4 (UDCLK) = 54 busy cycles.
  - Later runs: 28 busy cycles per point plus DWELL between points.
- A/D hold their last value after a write; they do not change in IDLE except on reset.

Test Plan:
- Reset, then start with mode=0, freq_start=48'h0147_AE14_7AE1 -> MRST high 10 cycles; writes 1D=10, 1E=44, 1F=00, 20=20; then writes 04=01, 05=47, 06=AE, 07=14, 08=7A, 09=E1; one 4-cycle UDCLK pulse; cur_freq=0x0147AE147AE1; done pulse; busy for 54 cycles.
- Second start, mode=0, freq_start=5 -> no MRST and no CR writes; FTW bytes 00,00,00,00,00,05; busy for 28 cycles.
- Sweep with start=100, stop=130, step=10 -> UDCLK pulses with cur_freq 100, 110, 120, 130 (4 pulses), DWELL gap between pulses, then one done pulse.
- Sweep with start=100, stop=125, step=10 -> points 100, 110, 120, 125. Overflow case: start=48'hFFFF_FFFF_FFF0, stop=48'hFFFF_FFFF_FFFF, step=0x20 -> points FFF0, FFFF, then done. Step=0 -> single point.
- start pulsed during a running sweep -> ignored; the point sequence is unchanged.
- rst_in asserted during the 3rd FTW byte of a sweep -> next cycle WR=1, A=0, D=0, busy=0, cur_freq=0. The next start re-runs MRST and CR init.
